// File: rtl/conv_window_gen.sv
// Sliding F x F x D window generator for the 3x3xD convolution unit.
// Raster pixels in, one packed window per valid position out (stride 1, no padding).

module conv_window_gen_linebuf #(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    // Asynchronous read returns the old entry, so one slot reads and writes in the same beat.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];
endmodule

module conv_window_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int origin_side = 256,
    parameter int D           = 3,
    parameter int F           = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [D*DATA_WIDTH-1:0]       pix_data,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [0:F*F*D*DATA_WIDTH-1]   win_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [7:0]                    win_row,
    output logic [7:0]                    win_col,
    output logic                          frame_done
);
    localparam int PW = D * DATA_WIDTH;
    localparam int WW = F * F * D * DATA_WIDTH;
    localparam int AW = (origin_side > 1) ? $clog2(origin_side) : 1;
    localparam logic [7:0] LAST  = 8'(origin_side - 1);
    localparam logic [7:0] EDGE  = 8'(F - 1);
    localparam logic [7:0] LASTW = 8'(origin_side - F);

    logic [7:0]                   r_col, r_row;
    logic [F-1:0][F-1:0][PW-1:0]  r_win;      // [row][col], row 0 oldest
    logic                         r_wv, r_fd;
    logic [7:0]                   r_wrow, r_wcol;
    logic [PW-1:0]                w_lb_rd [F-1];
    logic [F-1:0][PW-1:0]         w_colv;
    logic [0:WW-1]                w_pack;
    logic                         w_accept, w_emit;

    assign pix_ready = !r_wv || win_ready;
    assign w_accept  = pix_valid && pix_ready;
    assign w_emit    = w_accept && (r_row >= EDGE) && (r_col >= EDGE);

    // Row chain: buffer k holds row (row-F+1+k); each accept moves a column one buffer older.
    generate
        for (genvar k = 0; k < F - 1; k++) begin : g_lb
            conv_window_gen_linebuf #(
                .DEPTH (origin_side),
                .W     (PW),
                .AW    (AW)
            ) u_lb (
                .clk     (clk),
                .i_we    (w_accept),
                .i_addr  (r_col[AW-1:0]),
                .i_wdata (w_colv[k+1]),
                .o_rdata (w_lb_rd[k])
            );
        end
    endgenerate

    always_comb begin
        w_colv = '0;
        for (int k = 0; k < F - 1; k++) w_colv[k] = w_lb_rd[k];
        w_colv[F-1] = pix_data;
    end

    always_comb begin
        w_pack = '0;
        for (int d = 0; d < D; d++)
            for (int r = 0; r < F; r++)
                for (int c = 0; c < F; c++)
                    w_pack[((d*F + r)*F + c)*DATA_WIDTH +: DATA_WIDTH] =
                        r_win[r][c][d*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
            r_win <= '0;
        end else if (w_accept) begin
            if (r_col == LAST) begin
                r_col <= '0;
                r_row <= (r_row == LAST) ? 8'd0 : r_row + 8'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F - 1; c++) r_win[r][c] <= r_win[r][c+1];
                r_win[r][F-1] <= w_colv[r];
            end
        end
    end

    // The window register only shifts on accept, which is blocked while a window stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wv   <= 1'b0;
            r_fd   <= 1'b0;
            r_wrow <= '0;
            r_wcol <= '0;
        end else begin
            r_fd <= r_wv && win_ready && (r_wrow == LASTW) && (r_wcol == LASTW);
            if (w_emit) begin
                r_wv   <= 1'b1;
                r_wrow <= r_row - EDGE;
                r_wcol <= r_col - EDGE;
            end else if (win_ready) begin
                r_wv <= 1'b0;
            end
        end
    end

    assign win_data   = w_pack;
    assign win_valid  = r_wv;
    assign win_row    = r_wrow;
    assign win_col    = r_wcol;
    assign frame_done = r_fd;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 5x5 D=3 instance for directed cases,
// 8x8 D=1 instance for randomized handshake over three frames.

module tb_conv_window_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [47:0]  a_pd;  logic a_pv, a_pr, a_wv, a_wr, a_fd;
    logic [0:431] a_wd;  logic [7:0] a_row, a_col;
    logic [15:0]  b_pd;  logic b_pv, b_pr, b_wv, b_wr, b_fd;
    logic [0:143] b_wd;  logic [7:0] b_row, b_col;

    conv_window_gen #(.DATA_WIDTH(16), .origin_side(5), .D(3), .F(3)) u_a (
        .clk(clk), .reset(reset), .pix_data(a_pd), .pix_valid(a_pv), .pix_ready(a_pr),
        .win_data(a_wd), .win_valid(a_wv), .win_ready(a_wr), .win_row(a_row),
        .win_col(a_col), .frame_done(a_fd));

    conv_window_gen #(.DATA_WIDTH(16), .origin_side(8), .D(1), .F(3)) u_b (
        .clk(clk), .reset(reset), .pix_data(b_pd), .pix_valid(b_pv), .pix_ready(b_pr),
        .win_data(b_wd), .win_valid(b_wv), .win_ready(b_wr), .win_row(b_row),
        .win_col(b_col), .frame_done(b_fd));

    typedef struct packed {
        logic [7:0]        row;
        logic [7:0]        col;
        logic [26:0][15:0] el;
    } win_t;

    win_t wq[$];
    int   n_done;
    int   checks = 0;
    int   errors = 0;

    // Element i = d*9 + r*3 + c of window (wr,wc); channel d carries 100*d + pixel.
    function automatic logic [15:0] exp_el(int s, int wr, int wc, int i);
        int d, r, c;
        d = i / 9; r = (i % 9) / 3; c = i % 3;
        return 16'(100*d + (wr + r)*s + wc + c);
    endfunction

    function automatic logic [26:0][15:0] exp_win(int s, int nch, int wr, int wc);
        logic [26:0][15:0] e;
        e = '0;
        for (int i = 0; i < 9*nch; i++) e[i] = exp_el(s, wr, wc, i);
        return e;
    endfunction

    // Streams n_pix raster pixels into one instance and records every handshaken window.
    task automatic stream(input bit sel, input int n_pix, input int hold, input bit rnd,
                          input bit drain, output int lat, output bit stall_ok, output bit tmo);
        int ptr, cyc, acc, first, held, dr, s, p;
        bit wv, pr, fd, wr, pv, snap_v;
        logic [26:0][15:0] cur, snap;
        logic [7:0] crow, ccol;
        win_t w;
        ptr = 0; cyc = 0; acc = -1; first = -1; held = 0; dr = 0; snap_v = 0;
        snap = '0;
        s = sel ? 8 : 5;
        wq.delete(); n_done = 0; stall_ok = 1; tmo = 1; lat = -1;
        while (cyc < 5000) begin
            @(negedge clk);
            wv = sel ? b_wv : a_wv;
            if (rnd) wr = ($urandom_range(0, 1) == 1);
            else     wr = !(wv && held < hold);
            pv = (ptr < n_pix) && (!rnd || $urandom_range(0, 1) == 1);
            p  = ptr % (s*s);
            if (sel) begin
                b_wr = wr; b_pv = pv; b_pd = 16'(p);
            end else begin
                a_wr = wr; a_pv = pv;
                for (int c = 0; c < 3; c++) a_pd[c*16 +: 16] = 16'(100*c + p);
            end
            #1;
            pr   = sel ? b_pr : a_pr;
            fd   = sel ? b_fd : a_fd;
            crow = sel ? b_row : a_row;
            ccol = sel ? b_col : a_col;
            cur  = '0;
            for (int i = 0; i < 27; i++) begin
                if (!sel)      cur[i] = a_wd[i*16 +: 16];
                else if (i < 9) cur[i] = b_wd[i*16 +: 16];
            end
            if (fd) n_done++;
            if (wv && !wr) begin
                if (snap_v && cur !== snap) stall_ok = 0;
                if (pr) stall_ok = 0;
                snap = cur; snap_v = 1; held++;
            end
            if (wv && wr) begin
                w.row = crow; w.col = ccol; w.el = cur;
                wq.push_back(w);
                snap_v = 0;
                if (first < 0) first = cyc;
            end
            if (pv && pr) begin
                if (p == 2*s + 2 && acc < 0) acc = cyc;
                ptr++;
            end
            cyc++;
            if (ptr == n_pix) begin
                if (!drain) begin tmo = 0; break; end
                dr++;
                if (dr >= 4 && !wv) begin tmo = 0; break; end
            end
        end
        if (drain) begin
            if (sel) begin b_pv = 0; b_wr = 1; end
            else     begin a_pv = 0; a_wr = 1; end
        end
        if (acc >= 0 && first >= 0) lat = first - acc;
    endtask

    task automatic test_reset();
        reset = 1; a_pv = 0; b_pv = 0; a_wr = 1; b_wr = 1; a_pd = '0; b_pd = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_wv !== 1'b0) begin errors++; $display("FAIL reset_wv: got %b want 0", a_wv); end
        checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", a_fd); end
        checks++; if (a_wd !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", a_wd); end
        checks++; if (a_row !== 8'd0 || a_col !== 8'd0) begin errors++; $display("FAIL reset_rowcol: got %0d,%0d want 0,0", a_row, a_col); end
        checks++; if (a_pr !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b want 1", a_pr); end
        checks++; if (b_wv !== 1'b0) begin errors++; $display("FAIL reset_b_wv: got %b want 0", b_wv); end
        reset = 0;
    endtask

    task automatic test_basic();
        int lat; bit st, tmo;
        stream(0, 25, 0, 0, 1, lat, st, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_timeout: got timeout want finish"); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL basic_latency: got %0d want 1", lat); end
        checks++; if (wq.size() !== 9) begin errors++; $display("FAIL basic_count: got %0d want 9", wq.size()); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_frame_done: got %0d want 1", n_done); end
        for (int k = 0; k < wq.size() && k < 9; k++) begin
            checks++;
            if (wq[k].row !== 8'(k/3) || wq[k].col !== 8'(k%3) || wq[k].el !== exp_win(5, 3, k/3, k%3)) begin
                errors++;
                $display("FAIL basic_win%0d: got (%0d,%0d) %h want (%0d,%0d) %h", k, wq[k].row, wq[k].col,
                         wq[k].el, k/3, k%3, exp_win(5, 3, k/3, k%3));
            end
        end
    endtask

    task automatic test_channels();
        int lat; bit st, tmo;
        int ch1[9];
        ch1 = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
        stream(0, 25, 0, 0, 1, lat, st, tmo);
        checks++; if (tmo || wq.size() !== 9) begin errors++; $display("FAIL chan_count: got %0d want 9", wq.size()); end
        if (wq.size() > 0) begin
            for (int j = 0; j < 9; j++) begin
                checks++;
                if (wq[0].el[9+j] !== 16'(ch1[j])) begin
                    errors++; $display("FAIL chan1_el%0d: got %0d want %0d", 9+j, wq[0].el[9+j], ch1[j]);
                end
                checks++;
                if (wq[0].el[18+j] !== 16'(ch1[j] + 100)) begin
                    errors++; $display("FAIL chan2_el%0d: got %0d want %0d", 18+j, wq[0].el[18+j], ch1[j] + 100);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; bit st, tmo;
        stream(0, 25, 4, 0, 1, lat, st, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL bp_timeout: got timeout want finish"); end
        checks++; if (!st) begin errors++; $display("FAIL bp_stall: got unstable data or pix_ready high want stable"); end
        checks++; if (wq.size() !== 9) begin errors++; $display("FAIL bp_count: got %0d want 9", wq.size()); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL bp_frame_done: got %0d want 1", n_done); end
        for (int k = 0; k < wq.size() && k < 9; k++) begin
            checks++;
            if (wq[k].row !== 8'(k/3) || wq[k].col !== 8'(k%3) || wq[k].el !== exp_win(5, 3, k/3, k%3)) begin
                errors++; $display("FAIL bp_win%0d: got (%0d,%0d) %h", k, wq[k].row, wq[k].col, wq[k].el);
            end
        end
    endtask

    task automatic test_row_wrap();
        int lat; bit st, tmo;
        int w02[9], w10[9];
        w02 = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
        w10 = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
        stream(0, 25, 0, 0, 1, lat, st, tmo);
        checks++; if (tmo || wq.size() < 4) begin errors++; $display("FAIL wrap_count: got %0d want 9", wq.size()); end
        if (wq.size() >= 4) begin
            checks++; if (wq[2].row !== 8'd0 || wq[2].col !== 8'd2) begin errors++; $display("FAIL wrap_pos02: got (%0d,%0d) want (0,2)", wq[2].row, wq[2].col); end
            checks++; if (wq[3].row !== 8'd1 || wq[3].col !== 8'd0) begin errors++; $display("FAIL wrap_pos10: got (%0d,%0d) want (1,0)", wq[3].row, wq[3].col); end
            for (int j = 0; j < 9; j++) begin
                checks++; if (wq[2].el[j] !== 16'(w02[j])) begin errors++; $display("FAIL wrap02_el%0d: got %0d want %0d", j, wq[2].el[j], w02[j]); end
                checks++; if (wq[3].el[j] !== 16'(w10[j])) begin errors++; $display("FAIL wrap10_el%0d: got %0d want %0d", j, wq[3].el[j], w10[j]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit st, tmo;
        stream(0, 17, 0, 0, 0, lat, st, tmo);
        checks++; if (wq.size() !== 3) begin errors++; $display("FAIL mid_partial_count: got %0d want 3", wq.size()); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL mid_partial_done: got %0d want 0", n_done); end
        @(negedge clk);
        a_pv = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (a_wv !== 1'b0 || a_fd !== 1'b0) begin errors++; $display("FAIL mid_after_reset: got wv=%b fd=%b want 0,0", a_wv, a_fd); end
        stream(0, 25, 0, 0, 1, lat, st, tmo);
        checks++; if (tmo || wq.size() !== 9) begin errors++; $display("FAIL mid_count: got %0d want 9", wq.size()); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL mid_frame_done: got %0d want 1", n_done); end
        for (int k = 0; k < wq.size() && k < 9; k++) begin
            checks++;
            if (wq[k].row !== 8'(k/3) || wq[k].col !== 8'(k%3) || wq[k].el !== exp_win(5, 3, k/3, k%3)) begin
                errors++; $display("FAIL mid_win%0d: got (%0d,%0d) %h", k, wq[k].row, wq[k].col, wq[k].el);
            end
        end
    endtask

    task automatic test_random();
        int lat, kk; bit st, tmo;
        stream(1, 192, 0, 1, 1, lat, st, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL rnd_timeout: got timeout want finish"); end
        checks++; if (!st) begin errors++; $display("FAIL rnd_stall: got unstable stalled window want stable"); end
        checks++; if (wq.size() !== 108) begin errors++; $display("FAIL rnd_count: got %0d want 108", wq.size()); end
        checks++; if (n_done !== 3) begin errors++; $display("FAIL rnd_frame_done: got %0d want 3", n_done); end
        for (int k = 0; k < wq.size() && k < 108; k++) begin
            kk = k % 36;
            checks++;
            if (wq[k].row !== 8'(kk/6) || wq[k].col !== 8'(kk%6) || wq[k].el !== exp_win(8, 1, kk/6, kk%6)) begin
                errors++;
                $display("FAIL rnd_win%0d: got (%0d,%0d) %h want (%0d,%0d)", k, wq[k].row, wq[k].col, wq[k].el, kk/6, kk%6);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channels();
        test_backpressure();
        test_row_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
